stump_control: RTL and testbench
================================

Name: stump_control

Overview:
- Stump control unit: three-state FETCH/EXECUTE/MEMORY sequencer.
- Decodes the instruction register and drives the ALU function code, register-bank selects, operand-B source and memory strobes.
- Owns the 4-bit condition-code register {N,Z,V,C}, loaded from the ALU flags output, and evaluates Bcc conditions.
- Sits directly upstream of the ALU (sources func) and downstream of it (consumes flags).

Parameters:
- RESET_CC, 4'b0000, reset value of the condition-code register

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- ir  input  16  current instruction (external IR, loaded when ir_en=1)
- flags_in  input  4  ALU flags {N,Z,V,C}
- mem_ready  input  1  memory handshake; current FETCH/MEMORY access completes this cycle
- state  output  2  00 FETCH, 01 EXECUTE, 10 MEMORY
- alu_func  output  3  ALU function code
- srcA  output  3  register-bank read port A select
- srcB  output  3  register-bank read port B select
- dest  output  3  register-bank write select
- reg_write  output  1  register write enable
- shift_op  output  2  shifter operation on operand A
- opB_sel  output  2  00 REG, 01 IMM5 (sign-extended ir[4:0]), 10 IMM8 (sign-extended ir[7:0]), 11 CONST_ONE
- ir_en  output  1  load IR from memory data
- addr_en  output  1  load address register from ALU result
- addr_sel  output  1  0 PC (R7), 1 address register
- wb_sel  output  1  0 ALU result, 1 memory data
- mem_ren  output  1  memory read strobe
- mem_wen  output  1  memory write strobe
- cc  output  4  condition-code register {N,Z,V,C}

Behaviour:
- Reset and output style
  - Synchronous rst: state <= FETCH, cc <= RESET_CC.
  - All other outputs are combinational from state, ir, cc and mem_ready, so after reset they show FETCH values.
  - rst mid-instruction: abandon the instruction at the edge; no CC update that edge.
- Instruction fields
  - op=ir[15:13], type=ir[12], S/L-S/cond=ir[11] or ir[11:8], dest=ir[10:8], A=ir[7:5], B=ir[4:2], shift=ir[1:0].
- FETCH
  - mem_ren=1, addr_sel=0, ir_en=mem_ready.
  - PC increment: srcA=7, opB_sel=11, alu_func=ADD, dest=7, reg_write=mem_ready, wb_sel=0.
  - Stays in FETCH while mem_ready=0; moves to EXECUTE on mem_ready=1.
- EXECUTE, ALU ops (op 000..101)
  - alu_func=op, srcA=ir[7:5], srcB=ir[4:2], dest=ir[10:8], reg_write=1.
  - opB_sel = type ? 01 : 00; shift_op = type ? 00 : ir[1:0].
  - When ir[11]=1, cc <= flags_in at the end of EXECUTE.
  - Next state FETCH. A write to R7 is legal and acts as a jump.
- EXECUTE, LD/ST (op 110)
  - alu_func=ADD, operands as for ALU ops, addr_en=1, reg_write=0, no CC update.
  - Next state MEMORY.
- MEMORY
  - addr_sel=1.
  - LD (ir[11]=0): mem_ren=1, wb_sel=1, dest=ir[10:8], reg_write=mem_ready.
  - ST (ir[11]=1): mem_wen=1, srcA=ir[10:8] (store data), reg_write=0.
  - Holds in MEMORY while mem_ready=0; moves to FETCH on mem_ready=1. Strobes stay asserted while held.
- EXECUTE, Bcc (op 111)
  - taken = cond_eval(ir[11:8], cc), using the registered cc.
  - Datapath: srcA=7, opB_sel=10, alu_func=ADD, dest=7, reg_write=taken, no CC update.
  - Next state FETCH.
- Condition codes
  - 0 AL, 1 NV, 2 HI (!C&!Z), 3 LS (C|Z), 4 CC (!C), 5 CS (C), 6 NE (!Z), 7 EQ (Z).
  - 8 VC, 9 VS, A PL, B MI, C GE (N==V), D LT (N!=V), E GT (!Z&(N==V)), F LE (Z|(N!=V)).
- Default values
  - In any state, outputs not listed are 0.
  - State encoding 11 is unreachable; if entered, go to FETCH next edge.

Decomposition:
- Package stump_ctrl_pkg:
  - state encodings
  - ALU func codes (ADD, ADC, SUB, SBC, AND, OR, LDST, BCC)
  - opB_sel encodings
  - the 16 condition codes
- One combinational sub-module, stump_cond_eval (cond[3:0], cc[3:0] -> taken).

Test Plan:
- rst=1 for 2 cycles, then rst=0, mem_ready=1 -> in FETCH: state=00, cc=0000, srcA=7, dest=7, reg_write=1, ir_en=1, alu_func=000, opB_sel=11; next cycle state=01.
- ir=16'h0B28 (ADD S=1, R3=R1+R2), flags_in=4'b0100 -> EXECUTE: dest=3, srcA=1, srcB=2, reg_write=1; cc=0100 after the edge; next state FETCH. Repeat with ir=16'h0328 (S=0) -> cc unchanged.
- ir=16'hF705 (BEQ) with cc=0100 -> reg_write=1, dest=7, opB_sel=10. With cc=0000 -> reg_write=0. Also sweep all 16 conds over all 16 cc values against the table.
- ir=16'hD283 (LD R2,[R4+3]) -> EXECUTE: addr_en=1, opB_sel=01. Then mem_ready=0 for 2 cycles: MEMORY held, mem_ren=1, reg_write=0. Then mem_ready=1: reg_write=1, dest=2, wb_sel=1; next state FETCH.
- ir=16'hDA83 (ST R2) -> MEMORY: mem_wen=1, srcA=2, reg_write=0, addr_sel=1.
- rst=1 while in MEMORY with mem_ready=0 -> at the edge state=00, cc=0000, mem_wen=0 afterwards; FETCH with mem_ready=0 holds state=00 and reg_write=0.

Source files
------------

// File: rtl/stump_ctrl_pkg.sv
// Shared encodings for the Stump control unit: sequencer states, ALU function codes,
// operand-B source selects and branch condition codes.
package stump_ctrl_pkg;

  typedef enum logic [1:0] {
    StFetch   = 2'b00,
    StExecute = 2'b01,
    StMemory  = 2'b10,
    StUnused  = 2'b11
  } state_e;

  typedef enum logic [2:0] {
    FnAdd  = 3'd0,
    FnAdc  = 3'd1,
    FnSub  = 3'd2,
    FnSbc  = 3'd3,
    FnAnd  = 3'd4,
    FnOr   = 3'd5,
    FnLdst = 3'd6,
    FnBcc  = 3'd7
  } alu_func_e;

  typedef enum logic [1:0] {
    OpbReg  = 2'b00,
    OpbImm5 = 2'b01,
    OpbImm8 = 2'b10,
    OpbOne  = 2'b11
  } opb_sel_e;

  typedef enum logic [3:0] {
    CondAl, CondNv, CondHi, CondLs, CondCc, CondCs, CondNe, CondEq,
    CondVc, CondVs, CondPl, CondMi, CondGe, CondLt, CondGt, CondLe
  } cond_e;

  localparam logic [2:0] RegPc = 3'd7;

endpackage

// File: rtl/stump_cond_eval.sv
// Branch condition evaluator: decides whether a Bcc is taken from the condition field
// and the condition-code register {N,Z,V,C}.
module stump_cond_eval
  import stump_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] cc,
  output logic       taken
);

  logic n, z, v, c;
  logic base;

  assign {n, z, v, c} = cc;

  // Each odd condition is the inverse of the even one below it.
  always_comb begin
    base = 1'b0;
    case (cond_e'({cond[3:1], 1'b0}))
      CondAl:  base = 1'b1;
      CondHi:  base = ~c & ~z;
      CondCc:  base = ~c;
      CondNe:  base = ~z;
      CondVc:  base = ~v;
      CondPl:  base = ~n;
      CondGe:  base = (n == v);
      CondGt:  base = ~z & (n == v);
      default: base = 1'b0;
    endcase
  end

  assign taken = base ^ cond[0];

endmodule

// File: rtl/stump_control.sv
// Stump control unit: FETCH/EXECUTE/MEMORY sequencer that decodes the IR into datapath
// controls and owns the {N,Z,V,C} condition-code register.
module stump_control
  import stump_ctrl_pkg::*;
#(
  parameter logic [3:0] RESET_CC = 4'b0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic [3:0]  flags_in,
  input  logic        mem_ready,
  output logic [1:0]  state,
  output logic [2:0]  alu_func,
  output logic [2:0]  srcA,
  output logic [2:0]  srcB,
  output logic [2:0]  dest,
  output logic        reg_write,
  output logic [1:0]  shift_op,
  output logic [1:0]  opB_sel,
  output logic        ir_en,
  output logic        addr_en,
  output logic        addr_sel,
  output logic        wb_sel,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [3:0]  cc
);

  state_e     state_q, state_d;
  logic [3:0] cc_q, cc_d;
  logic [2:0] op;
  logic       is_imm;
  logic       taken;

  assign op     = ir[15:13];
  assign is_imm = ir[12];

  stump_cond_eval u_cond_eval (
    .cond  (ir[11:8]),
    .cc    (cc_q),
    .taken (taken)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      cc_q    <= RESET_CC;
    end else begin
      state_q <= state_d;
      cc_q    <= cc_d;
    end
  end

  always_comb begin
    state_d   = StFetch;
    cc_d      = cc_q;
    alu_func  = FnAdd;
    srcA      = 3'd0;
    srcB      = 3'd0;
    dest      = 3'd0;
    reg_write = 1'b0;
    shift_op  = 2'b00;
    opB_sel   = OpbReg;
    ir_en     = 1'b0;
    addr_en   = 1'b0;
    addr_sel  = 1'b0;
    wb_sel    = 1'b0;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;

    case (state_q)
      StFetch: begin
        // Instruction read overlaps with PC <= PC + 1.
        mem_ren   = 1'b1;
        ir_en     = mem_ready;
        srcA      = RegPc;
        opB_sel   = OpbOne;
        dest      = RegPc;
        reg_write = mem_ready;
        state_d   = mem_ready ? StExecute : StFetch;
      end

      StExecute: begin
        if (op == FnBcc) begin
          srcA      = RegPc;
          opB_sel   = OpbImm8;
          dest      = RegPc;
          reg_write = taken;
          state_d   = StFetch;
        end else begin
          srcA     = ir[7:5];
          srcB     = ir[4:2];
          opB_sel  = is_imm ? OpbImm5 : OpbReg;
          shift_op = is_imm ? 2'b00 : ir[1:0];
          if (op == FnLdst) begin
            addr_en = 1'b1;
            state_d = StMemory;
          end else begin
            alu_func  = op;
            dest      = ir[10:8];
            reg_write = 1'b1;
            state_d   = StFetch;
            if (ir[11]) cc_d = flags_in;
          end
        end
      end

      StMemory: begin
        addr_sel = 1'b1;
        if (ir[11]) begin
          mem_wen = 1'b1;
          srcA    = ir[10:8];
        end else begin
          mem_ren   = 1'b1;
          wb_sel    = 1'b1;
          dest      = ir[10:8];
          reg_write = mem_ready;
        end
        state_d = mem_ready ? StFetch : StMemory;
      end

      default: state_d = StFetch;
    endcase
  end

  assign state = state_q;
  assign cc    = cc_q;

endmodule

// File: tb/tb_stump_control.sv
// Scoreboard bench for stump_control: a driver pushes reference-model expectations,
// a negedge monitor pops and compares against the DUT outputs.
module tb_stump_control;

  typedef struct packed {
    logic [1:0] state;
    logic [2:0] alu_func;
    logic [2:0] src_a;
    logic [2:0] src_b;
    logic [2:0] dest;
    logic       reg_write;
    logic [1:0] shift_op;
    logic [1:0] opb_sel;
    logic       ir_en;
    logic       addr_en;
    logic       addr_sel;
    logic       wb_sel;
    logic       mem_ren;
    logic       mem_wen;
    logic [3:0] cc;
  } obs_t;

  localparam logic [3:0] ResetCc = 4'b0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ir;
  logic [3:0]  flags_in;
  logic        mem_ready;
  logic [1:0]  state;
  logic [2:0]  alu_func, srcA, srcB, dest;
  logic        reg_write;
  logic [1:0]  shift_op, opB_sel;
  logic        ir_en, addr_en, addr_sel, wb_sel, mem_ren, mem_wen;
  logic [3:0]  cc;

  stump_control #(.RESET_CC(ResetCc)) dut (
    .clk       (clk),
    .rst       (rst),
    .ir        (ir),
    .flags_in  (flags_in),
    .mem_ready (mem_ready),
    .state     (state),
    .alu_func  (alu_func),
    .srcA      (srcA),
    .srcB      (srcB),
    .dest      (dest),
    .reg_write (reg_write),
    .shift_op  (shift_op),
    .opB_sel   (opB_sel),
    .ir_en     (ir_en),
    .addr_en   (addr_en),
    .addr_sel  (addr_sel),
    .wb_sel    (wb_sel),
    .mem_ren   (mem_ren),
    .mem_wen   (mem_wen),
    .cc        (cc)
  );

  always #5 clk = ~clk;

  obs_t  act;
  obs_t  exp_q[$];
  string name_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  always_comb begin
    act = '0;
    act.state     = state;
    act.alu_func  = alu_func;
    act.src_a     = srcA;
    act.src_b     = srcB;
    act.dest      = dest;
    act.reg_write = reg_write;
    act.shift_op  = shift_op;
    act.opb_sel   = opB_sel;
    act.ir_en     = ir_en;
    act.addr_en   = addr_en;
    act.addr_sel  = addr_sel;
    act.wb_sel    = wb_sel;
    act.mem_ren   = mem_ren;
    act.mem_wen   = mem_wen;
    act.cc        = cc;
  end

  // Reference model: phase is 0 fetch, 1 execute, 2 memory.
  int         m_phase = 0;
  logic [3:0] m_cc = ResetCc;
  bit         m_valid = 0;

  function automatic bit cond_ok(input logic [3:0] k, input logic [3:0] f);
    bit n, z, v, c;
    n = f[3]; z = f[2]; v = f[1]; c = f[0];
    case (k)
      4'h0: return 1'b1;
      4'h1: return 1'b0;
      4'h2: return !c && !z;
      4'h3: return c || z;
      4'h4: return !c;
      4'h5: return c;
      4'h6: return !z;
      4'h7: return z;
      4'h8: return !v;
      4'h9: return v;
      4'hA: return !n;
      4'hB: return n;
      4'hC: return n == v;
      4'hD: return n != v;
      4'hE: return !z && (n == v);
      default: return z || (n != v);
    endcase
  endfunction

  function automatic obs_t model_out(input int ph, input logic [15:0] i, input logic [3:0] c,
                                     input logic mr);
    obs_t e;
    int   op;
    e = '0;
    op = int'(i[15:13]);
    e.state = ph[1:0];
    e.cc = c;
    if (ph == 0) begin
      e.mem_ren = 1; e.ir_en = mr; e.src_a = 7; e.opb_sel = 2'b11; e.dest = 7;
      e.reg_write = mr;
    end else if (ph == 1) begin
      if (op == 7) begin
        e.src_a = 7; e.opb_sel = 2'b10; e.dest = 7; e.reg_write = cond_ok(i[11:8], c);
      end else begin
        e.src_a = i[7:5];
        e.src_b = i[4:2];
        e.opb_sel = i[12] ? 2'b01 : 2'b00;
        e.shift_op = i[12] ? 2'b00 : i[1:0];
        if (op == 6) e.addr_en = 1;
        else begin
          e.alu_func = i[15:13]; e.dest = i[10:8]; e.reg_write = 1;
        end
      end
    end else begin
      e.addr_sel = 1;
      if (!i[11]) begin
        e.mem_ren = 1; e.wb_sel = 1; e.dest = i[10:8]; e.reg_write = mr;
      end else begin
        e.mem_wen = 1; e.src_a = i[10:8];
      end
    end
    return e;
  endfunction

  task automatic drive(input logic r, input logic [15:0] i, input logic [3:0] f,
                       input logic mr, input string nm);
    int op;
    rst = r; ir = i; flags_in = f; mem_ready = mr;
    if (m_valid) begin
      exp_q.push_back(model_out(m_phase, i, m_cc, mr));
      name_q.push_back(nm);
    end
    op = int'(i[15:13]);
    if (r) begin
      m_phase = 0; m_cc = ResetCc; m_valid = 1;
    end else if (m_valid) begin
      case (m_phase)
        0: m_phase = mr ? 1 : 0;
        1: begin
          if (op <= 5 && i[11]) m_cc = f;
          m_phase = (op == 6) ? 2 : 0;
        end
        default: m_phase = mr ? 0 : 2;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    obs_t  e;
    string nm;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      nm = name_q.pop_front();
      vectors++;
      if (act !== e) begin
        miscompares++;
        $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, e, $time);
      end
    end
  end

  initial begin
    rst = 1; ir = '0; flags_in = '0; mem_ready = 1;
    drive(1, 16'h0000, 4'h0, 1, "reset0");
    drive(1, 16'h0000, 4'h0, 1, "reset1");
    drive(0, 16'h0000, 4'h0, 1, "fetch_after_reset");
    drive(0, 16'h0B28, 4'b0100, 1, "exec_add_s");
    drive(0, 16'h0000, 4'h0, 1, "fetch_cc_loaded");
    drive(0, 16'h0328, 4'b1011, 1, "exec_add_nos");
    drive(0, 16'h0000, 4'h0, 1, "fetch_cc_kept");
    drive(0, 16'hF705, 4'h0, 1, "beq_taken");
    drive(0, 16'h0000, 4'h0, 1, "fetch");
    drive(0, 16'h0800, 4'b0000, 1, "exec_clear_cc");
    drive(0, 16'h0000, 4'h0, 1, "fetch");
    drive(0, 16'hF705, 4'h0, 1, "beq_not_taken");
    drive(0, 16'h0000, 4'h0, 1, "fetch");
    drive(0, 16'hD283, 4'h0, 1, "ld_exec");
    drive(0, 16'hD283, 4'h0, 0, "ld_mem_wait0");
    drive(0, 16'hD283, 4'h0, 0, "ld_mem_wait1");
    drive(0, 16'hD283, 4'h0, 1, "ld_mem_done");
    drive(0, 16'h0000, 4'h0, 1, "fetch_after_ld");
    drive(0, 16'hDA83, 4'h0, 1, "st_exec");
    drive(0, 16'hDA83, 4'h0, 0, "st_mem_wait");
    drive(1, 16'hDA83, 4'h0, 0, "st_mem_reset");
    drive(0, 16'h0000, 4'h0, 0, "fetch_hold0");
    drive(0, 16'h0000, 4'h0, 0, "fetch_hold1");

    // Sweep every condition against every cc value.
    for (int f = 0; f < 16; f++) begin
      for (int k = 0; k < 16; k++) begin
        drive(0, 16'($urandom), 4'h0, 1, "sweep_fetch");
        drive(0, {5'b00001, 11'($urandom)}, 4'(f), 1, "sweep_set_cc");
        drive(0, 16'($urandom), 4'h0, 1, "sweep_fetch");
        drive(0, {4'hE, 4'(k), 8'($urandom)}, 4'h0, 1, "sweep_bcc");
      end
    end

    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 49) == 0), 16'($urandom), 4'($urandom),
            ($urandom_range(0, 3) != 0), "random");
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
